// File: rtl/srp16_pkg.sv
// Shared SRP16 bus definitions: bus widths and the memory bridge state encoding.
package srp16_pkg;

  localparam int unsigned SRP16_AW = 16;
  localparam int unsigned SRP16_DW = 16;
  localparam int unsigned SRP16_MW = 8;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_slot_timer.sv
// Byte-slot timer: a down-counter loaded with the wait-state count at slot start,
// flagging the first (address setup) and last cycle of each slot.
module mem_slot_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       active,
  input  logic [3:0] wait_states,
  output logic       slot_first,
  output logic       slot_last
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (start) begin
      cnt_q <= wait_states;
    end else if (active && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    slot_first = active && (cnt_q == wait_states);
    slot_last  = active && (cnt_q == 4'd0);
  end

endmodule

// File: rtl/mem_bridge.sv
// SRP16 memory-side responder: turns 8/16-bit bus requests into one or two timed
// byte accesses on an external 8-bit asynchronous SRAM.
module mem_bridge
  import srp16_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SRP16_AW-1:0] addr,
  input  logic [SRP16_DW-1:0] wdata,
  input  logic                rd,
  input  logic                wr,
  input  logic                word,
  output logic                ready,
  output logic                busy,
  output logic [SRP16_DW-1:0] rdata,
  output logic [SRP16_AW-1:0] mem_addr,
  output logic [SRP16_MW-1:0] mem_dout,
  input  logic [SRP16_MW-1:0] mem_din,
  output logic                mem_oe,
  output logic                mem_we
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

  mem_state_t          state_q;
  logic [SRP16_AW-1:0] addr_q;
  logic [SRP16_DW-1:0] wdata_q;
  logic                word_q;
  logic                op_rd_q;

  logic slot_start;
  logic slot_active;
  logic slot_first;
  logic slot_last;

  // A new slot starts on accept and on the LO->HI handover of a word access.
  always_comb begin
    slot_start  = ((state_q == IDLE) && (rd || wr)) ||
                  ((state_q == LO) && slot_last && word_q);
    slot_active = (state_q == LO) || (state_q == HI);
  end

  mem_slot_timer u_slot_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (slot_start),
    .active      (slot_active),
    .wait_states (WaitCnt),
    .slot_first  (slot_first),
    .slot_last   (slot_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= 1'b0;
      op_rd_q  <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd || wr) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            word_q   <= word;
            op_rd_q  <= rd;
            busy     <= 1'b1;
            mem_addr <= addr;
            mem_dout <= wdata[7:0];
            mem_oe   <= rd;
            mem_we   <= 1'b0;
            state_q  <= LO;
          end
        end
        LO: begin
          // Write strobe covers every cycle after address setup.
          if (slot_first && !op_rd_q) mem_we <= 1'b1;
          if (slot_last) begin
            mem_we <= 1'b0;
            if (op_rd_q) begin
              rdata[7:0] <= mem_din;
              if (!word_q) rdata[15:8] <= 8'h00;
            end
            if (word_q) begin
              mem_addr <= addr_q + 16'd1;
              mem_dout <= wdata_q[15:8];
              state_q  <= HI;
            end else begin
              mem_oe  <= 1'b0;
              ready   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        HI: begin
          if (slot_first && !op_rd_q) mem_we <= 1'b1;
          if (slot_last) begin
            mem_we <= 1'b0;
            if (op_rd_q) rdata[15:8] <= mem_din;
            mem_oe  <= 1'b0;
            ready   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: two instances (W=1 and W=2) each backed by an SRAM model.
module tb_mem_bridge;

  logic        clk;
  logic        reset_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd;
  logic        wr;
  logic        word;

  logic        ready1, busy1, mem_oe1, mem_we1;
  logic [15:0] rdata1, mem_addr1;
  logic [7:0]  mem_dout1, mem_din1;
  logic        ready2, busy2, mem_oe2, mem_we2;
  logic [15:0] rdata2, mem_addr2;
  logic [7:0]  mem_dout2, mem_din2;

  logic [7:0] sram1 [65536];
  logic [7:0] sram2 [65536];

  int total;
  int bad;

  mem_bridge #(.WAIT_STATES(1)) u_w1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wdata    (wdata),
    .rd       (rd),
    .wr       (wr),
    .word     (word),
    .ready    (ready1),
    .busy     (busy1),
    .rdata    (rdata1),
    .mem_addr (mem_addr1),
    .mem_dout (mem_dout1),
    .mem_din  (mem_din1),
    .mem_oe   (mem_oe1),
    .mem_we   (mem_we1)
  );

  mem_bridge #(.WAIT_STATES(2)) u_w2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wdata    (wdata),
    .rd       (rd),
    .wr       (wr),
    .word     (word),
    .ready    (ready2),
    .busy     (busy2),
    .rdata    (rdata2),
    .mem_addr (mem_addr2),
    .mem_dout (mem_dout2),
    .mem_din  (mem_din2),
    .mem_oe   (mem_oe2),
    .mem_we   (mem_we2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_din1 = mem_oe1 ? sram1[mem_addr1] : 8'h00;
  assign mem_din2 = mem_oe2 ? sram2[mem_addr2] : 8'h00;

  always @(posedge clk) begin
    if (mem_we1) sram1[mem_addr1] = mem_dout1;
    if (mem_we2) sram2[mem_addr2] = mem_dout2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || busy2) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (busy1 || busy2) begin
      bad++;
      $display("FAIL wait_idle: busy1=%0b busy2=%0b required 0 0", busy1, busy2);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd = 0; wr = 0; word = 0; addr = 16'h0; wdata = 16'h0;
    tick();
    tick();
    total++;
    if ({ready1, busy1, mem_oe1, mem_we1} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl1: got %b required 0000", {ready1, busy1, mem_oe1, mem_we1});
    end
    total++;
    if ({rdata1, mem_addr1, mem_dout1} !== 40'h0) begin
      bad++; $display("FAIL reset_data1: got %h required 0", {rdata1, mem_addr1, mem_dout1});
    end
    total++;
    if ({ready2, busy2, mem_oe2, mem_we2, rdata2, mem_addr2, mem_dout2} !== 44'h0) begin
      bad++; $display("FAIL reset_w2: got %h required 0",
                      {ready2, busy2, mem_oe2, mem_we2, rdata2, mem_addr2, mem_dout2});
    end
    reset_n = 1'b1;
    rd = 1'b1; addr = 16'h0000; word = 1'b0;
    tick();
    rd = 1'b0;
    total++;
    if ({busy1, mem_oe1} !== 2'b11) begin
      bad++; $display("FAIL reset_first_accept: busy,oe got %b required 11", {busy1, mem_oe1});
    end
    wait_idle();
  endtask

  task automatic test_word_read();
    logic [15:0] exp_a;
    rd = 1'b1; word = 1'b1; addr = 16'h0100;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i < 2) ? 16'h0100 : 16'h0101;
      total++;
      if ({mem_oe1, ready1, mem_addr1} !== {1'b1, 1'b0, exp_a}) begin
        bad++; $display("FAIL word_read_slot%0d: oe,ready,addr got %b %b %h required 1 0 %h",
                        i, mem_oe1, ready1, mem_addr1, exp_a);
      end
      tick();
    end
    total++;
    if ({ready1, busy1, mem_oe1} !== 3'b110) begin
      bad++; $display("FAIL word_read_ready: ready,busy,oe got %b required 110",
                      {ready1, busy1, mem_oe1});
    end
    total++;
    if (rdata1 !== 16'h1234) begin
      bad++; $display("FAIL word_read_data: got %h required 1234", rdata1);
    end
    tick();
    total++;
    if ({ready1, busy1} !== 2'b00) begin
      bad++; $display("FAIL word_read_after: ready,busy got %b required 00", {ready1, busy1});
    end
    wait_idle();
  endtask

  task automatic test_byte_write_read();
    logic [2:0] exp_we;
    exp_we = 3'b110;
    wr = 1'b1; word = 1'b0; addr = 16'h2001; wdata = 16'hBEEF;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_we2, mem_addr2, mem_dout2} !== {exp_we[i], 16'h2001, 8'hEF}) begin
        bad++; $display("FAIL byte_write_slot%0d: we,addr,dout got %b %h %h required %b 2001 ef",
                        i, mem_we2, mem_addr2, mem_dout2, exp_we[i]);
      end
      tick();
    end
    total++;
    if ({ready2, mem_we2} !== 2'b10) begin
      bad++; $display("FAIL byte_write_ready: ready,we got %b required 10", {ready2, mem_we2});
    end
    total++;
    if (sram2[16'h2001] !== 8'hEF) begin
      bad++; $display("FAIL byte_write_mem: got %h required ef", sram2[16'h2001]);
    end
    total++;
    if (rdata2 !== 16'h1234) begin
      bad++; $display("FAIL byte_write_rdata_hold: got %h required 1234", rdata2);
    end
    wait_idle();
    rd = 1'b1; word = 1'b0; addr = 16'h2001;
    tick();
    rd = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({ready2, rdata2} !== {1'b1, 16'h00EF}) begin
      bad++; $display("FAIL byte_read: ready,rdata got %b %h required 1 00ef", ready2, rdata2);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    wr = 1'b1; word = 1'b1; addr = 16'hFFFF; wdata = 16'hA55A;
    tick();
    wr = 1'b0;
    wait_idle();
    total++;
    if ({sram1[16'hFFFF], sram1[16'h0000]} !== 16'h5AA5) begin
      bad++; $display("FAIL wrap_w1: got %h %h required 5a a5", sram1[16'hFFFF], sram1[16'h0000]);
    end
    total++;
    if ({sram2[16'hFFFF], sram2[16'h0000]} !== 16'h5AA5) begin
      bad++; $display("FAIL wrap_w2: got %h %h required 5a a5", sram2[16'hFFFF], sram2[16'h0000]);
    end
  endtask

  task automatic test_collision_ignore();
    int nready;
    nready = 0;
    rd = 1'b1; wr = 1'b1; word = 1'b1; addr = 16'h0100; wdata = 16'hDEAD;
    tick();
    rd = 1'b0; wr = 1'b0;
    tick();
    wr = 1'b1; word = 1'b0; addr = 16'h3000; wdata = 16'h7777;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ready1) nready++;
      tick();
    end
    total++;
    if (nready !== 1) begin
      bad++; $display("FAIL collision_ready_count: got %0d required 1", nready);
    end
    total++;
    if (rdata1 !== 16'h1234) begin
      bad++; $display("FAIL collision_rdata: got %h required 1234", rdata1);
    end
    total++;
    if ({sram1[16'h0101], sram1[16'h0100], sram1[16'h3000]} !== 24'h123400) begin
      bad++; $display("FAIL collision_mem: got %h %h %h required 12 34 00",
                      sram1[16'h0101], sram1[16'h0100], sram1[16'h3000]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_write();
    int nready;
    nready = 0;
    wr = 1'b1; word = 1'b1; addr = 16'h4000; wdata = 16'hC3A5;
    tick();
    wr = 1'b0;
    tick(); tick(); tick(); tick();
    total++;
    if ({mem_we2, mem_addr2} !== {1'b1, 16'h4001}) begin
      bad++; $display("FAIL midreset_pre: we,addr got %b %h required 1 4001", mem_we2, mem_addr2);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_we2, busy2, mem_addr2} !== 18'h0) begin
      bad++; $display("FAIL midreset_async: we,busy,addr got %b %b %h required 0 0 0000",
                      mem_we2, busy2, mem_addr2);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ready2) nready++;
      tick();
    end
    total++;
    if ({nready, busy2} !== {32'd0, 1'b0}) begin
      bad++; $display("FAIL midreset_no_ready: ready_count,busy got %0d %b required 0 0",
                      nready, busy2);
    end
    total++;
    if ({sram2[16'h4000], sram2[16'h4001]} !== 16'hA500) begin
      bad++; $display("FAIL midreset_mem: got %h %h required a5 00",
                      sram2[16'h4000], sram2[16'h4001]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      sram1[i] = 8'h00;
      sram2[i] = 8'h00;
    end
    sram1[16'h0100] = 8'h34; sram1[16'h0101] = 8'h12;
    sram2[16'h0100] = 8'h34; sram2[16'h0101] = 8'h12;
    test_reset();
    test_word_read();
    test_byte_write_read();
    test_wrap();
    test_collision_ignore();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Memory-side responder for the SRP16 address/data buses. Accepts 16-bit byte-addressed read/write requests (instruction fetch via PC address, load/store via ALU address) and services each as one or two byte accesses to an external 8-bit asynchronous SRAM, with programmable wait states. Returns a one-cycle `ready` pulse with read data, making it the counterpart to the PC/address-bus drivers in the core.

## Interface
- `WAIT_STATES`, default 1: extra cycles per byte slot; legal range 1..15.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `addr` input 16: byte address of request (low byte address for word access).
- `wdata` input 16: write data; byte writes use `wdata[7:0]`.
- `rd` input 1: read request.
- `wr` input 1: write request.
- `word` input 1: 1 = 16-bit access, 0 = 8-bit access.
- `ready` output 1: one-cycle completion pulse.
- `busy` output 1: high from accept until the cycle `ready` is high (inclusive).
- `rdata` output 16: read result; byte reads zero-extended.
- `mem_addr` output 16: SRAM byte address.
- `mem_dout` output 8: SRAM write data.
- `mem_din` input 8: SRAM read data.
- `mem_oe` output 1: SRAM output enable, active-high.
- `mem_we` output 1: SRAM write enable, active-high.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: if `rd` or `wr` sampled high, latch `addr`, `wdata`, `word` and op (`rd` wins if both high), go to LO; otherwise stay. Requests are sampled only in IDLE; in any other state they are ignored.
- LO: byte slot at latched `addr`, data byte `wdata[7:0]`. Afterwards go to HI if `word`, else DONE.
- HI: byte slot at `addr + 1` (16-bit wrap: 0xFFFF -> 0x0000), data byte `wdata[15:8]`. Afterwards go to DONE.
- DONE: `ready` = 1 for one cycle, then IDLE.
- Byte order is little-endian: low byte at `addr`, high byte at `addr + 1`.
- A byte slot lasts `WAIT_STATES + 1` cycles. Slot cycle 0 is address setup.
  - `mem_addr` and `mem_dout` are stable for the whole slot.
  - Read slot: `mem_oe` = 1 for every cycle of the slot.
  - Write slot: `mem_we` = 0 in cycle 0 and 1 in cycles 1..`WAIT_STATES`.
- Read capture: `mem_din` is sampled at the final edge of the slot. The LO slot fills `rdata[7:0]`; the HI slot fills `rdata[15:8]`. A byte read forces `rdata[15:8]` = 0.
- `rdata` is valid during `ready` and holds until the next accepted read.
- A write leaves `rdata` unchanged.
- Outside slots, `mem_oe` = `mem_we` = 0; `mem_addr` and `mem_dout` hold their last values.

## Timing
- Reset values: state IDLE, `ready` 0, `busy` 0, `rdata` 0x0000, `mem_addr` 0x0000, `mem_dout` 0x00, `mem_oe` 0, `mem_we` 0, slot counter 0.
- Let W = `WAIT_STATES`, with the accept at edge E0.
  - Byte access: `ready` is high in the cycle after edge E0 + (W+1).
  - Word access: `ready` is high in the cycle after edge E0 + 2(W+1).
- Minimum spacing between accepts is one IDLE cycle after DONE. Back-to-back word reads with W = 1 therefore complete every 6 cycles.
- `busy` rises in the cycle after the accept edge.
- `reset_n` low at any point aborts immediately: all outputs return to their reset values and no `ready` is produced. A partially written word may leave the SRAM low byte already updated; this is accepted behaviour.
- A request held high across `ready` is re-accepted in the following IDLE cycle. The requester must drop `rd`/`wr` in the `ready` cycle.

## Structure
- Shared package `srp16_pkg`:
  - state enum `mem_state_t` (IDLE, LO, HI, DONE);
  - constants `SRP16_AW = 16`, `SRP16_DW = 16`, `SRP16_MW = 8`.
- Sub-module `mem_slot_timer`:
  - 4-bit down-counter loaded with W at slot start;
  - outputs `slot_first` and `slot_last`;
  - reused by future peripheral bus bridges.
- FSM, request latches and read-data assembly stay in `mem_bridge`.

## Test plan
- Reset: with `reset_n` low then released, all outputs read as 0; `rd` = 1, `addr` = 0x0000 held for one cycle is accepted on the first edge after release.
- Word read, W = 1: SRAM[0x0100] = 0x34, SRAM[0x0101] = 0x12, `rd` with `word` = 1, `addr` = 0x0100 -> `mem_oe` high for 4 cycles, `mem_addr` 0x0100 then 0x0101, `ready` 4 edges after accept, `rdata` = 0x1234.
- Byte write then byte read, W = 2: `wr`, `word` = 0, `addr` = 0x2001, `wdata` = 0xBEEF -> one 3-cycle slot, `mem_we` low then high, high, SRAM[0x2001] = 0xEF; a following byte read of 0x2001 gives `rdata` = 0x00EF.
- Wrap: word write at `addr` = 0xFFFF, `wdata` = 0xA55A -> SRAM[0xFFFF] = 0x5A, SRAM[0x0000] = 0xA5.
- Collision and ignore: `rd` and `wr` both high -> a read is performed and SRAM is unchanged; `wr` pulsed while `busy` -> ignored, no extra `ready`.
- Reset mid-word-write during the HI slot -> `mem_we` drops asynchronously, no `ready`; the low byte is written and the high byte is untouched.
